// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;

    typedef enum logic [1:0] {
        RUN  = 2'd0,
        WAIT = 2'd1,
        DROP = 2'd2
    } state_t;

    localparam int PC_INC = 4;

    typedef logic [31:0] addr_t;
    typedef logic [31:0] inst_t;

    typedef struct packed {
        inst_t inst;
        addr_t pc;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch FIFO: synchronous push/pop, flush, occupancy count, async active-low reset.
module fetch_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 64,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic [CNT_W-1:0] count_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push;
    logic             do_pop;

    assign do_pop  = pop_i && (count_q != '0);
    // A push into a full FIFO is only legal when the head leaves in the same cycle.
    assign do_push = push_i && ((count_q != CNT_W'(DEPTH)) || do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            if (do_push && !do_pop)      count_d = count_q + CNT_W'(1);
            else if (!do_push && do_pop) count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush_i) mem_q[wr_ptr_q] <= wdata_i;
    end

    // Empty FIFO presents zeros so the decode-side outputs are clean after reset/flush.
    assign rdata_o = (count_q != '0) ? mem_q[rd_ptr_q] : '0;
    assign count_o = count_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC, single-outstanding imem request FSM, redirect/flush, prefetch FIFO.
// Optional FETCH_PERF_EN adds perf_fetched / perf_bubbles counters.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int                ADDR_W     = 32,
    parameter int                DATA_W     = 32,
    parameter logic [ADDR_W-1:0] RESET_PC   = '0,
    parameter int                FIFO_DEPTH = 2
) (
    input  logic              clk,
    input  logic              reset,
    output logic              imem_req_valid,
    input  logic              imem_req_ready,
    output logic [ADDR_W-1:0] imem_req_addr,
    input  logic              imem_rsp_valid,
    input  logic [DATA_W-1:0] imem_rsp_data,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [DATA_W-1:0] inst,
    output logic [ADDR_W-1:0] inst_pc
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]       perf_fetched,
    output logic [31:0]       perf_bubbles
`endif
);

    localparam int                CNT_W      = $clog2(FIFO_DEPTH) + 1;
    localparam int                ENT_W      = DATA_W + ADDR_W;
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(3);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] req_pc_q, req_pc_d;
    logic              en_q;
    logic [CNT_W-1:0]  fifo_count;
    logic [ENT_W-1:0]  fifo_head;
    logic              accept;
    logic              push;
    logic              pop;
    logic              flush;

    // en_q holds off the first request until the cycle after reset release.
    assign imem_req_valid = en_q && (state_q == RUN) && (fifo_count < CNT_W'(FIFO_DEPTH));
    assign imem_req_addr  = pc_q;
    assign accept         = imem_req_valid && imem_req_ready;
    assign inst_valid     = (fifo_count != '0);
    assign pop            = inst_valid && inst_ready && !redirect_valid;
    assign flush          = redirect_valid;

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        req_pc_d = req_pc_q;
        push     = 1'b0;
        if (redirect_valid) begin
            pc_d = redirect_pc & ALIGN_MASK;
            unique case (state_q)
                RUN:        state_d = accept ? DROP : RUN;
                WAIT, DROP: state_d = imem_rsp_valid ? RUN : DROP;
                default:    state_d = RUN;
            endcase
        end else begin
            unique case (state_q)
                RUN: begin
                    if (accept) begin
                        state_d  = WAIT;
                        req_pc_d = pc_q;
                        pc_d     = pc_q + ADDR_W'(PC_INC);
                    end
                end
                WAIT: begin
                    if (imem_rsp_valid) begin
                        push    = 1'b1;
                        state_d = RUN;
                    end
                end
                DROP: begin
                    if (imem_rsp_valid) state_d = RUN;
                end
                default: state_d = RUN;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= RUN;
            pc_q    <= RESET_PC & ALIGN_MASK;
            en_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            en_q    <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        req_pc_q <= req_pc_d;
    end

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (ENT_W)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (reset),
        .flush_i (flush),
        .push_i  (push),
        .wdata_i ({imem_rsp_data, req_pc_q}),
        .pop_i   (pop),
        .rdata_o (fifo_head),
        .count_o (fifo_count)
    );

    assign inst    = fifo_head[ENT_W-1 -: DATA_W];
    assign inst_pc = fifo_head[ADDR_W-1:0];

`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetched_q, perf_bubbles_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            perf_fetched_q <= '0;
            perf_bubbles_q <= '0;
        end else begin
            if (push)        perf_fetched_q <= perf_fetched_q + 32'd1;
            if (!inst_valid) perf_bubbles_q <= perf_bubbles_q + 32'd1;
        end
    end

    assign perf_fetched = perf_fetched_q;
    assign perf_bubbles = perf_bubbles_q;
`else
    // Performance counters compiled out.
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus a randomized run scored
// against an in-order fetch/deliver PC model and a latency-programmable memory model.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req_valid, imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        inst_valid, inst_ready;
    logic [31:0] inst, inst_pc;
    logic        req_valid2, inst_valid2;
    logic [31:0] req_addr2, inst2, inst_pc2;
`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetched, perf_bubbles, perf_fetched2, perf_bubbles2;
`endif

    int checks = 0;
    int failures = 0;

    // memory model and per-cycle observations
    logic        mem_pend;
    int          mem_wait, mem_lat;
    logic [31:0] mem_addr;
    logic        o_rv, o_iv, o_rv2, o_iv2;
    logic [31:0] o_ra, o_inst, o_ipc, o_ra2, o_ipc2;
    logic        acc, acc2, pop, pop2, rsp_fire, pend_before;

    always #5 clk = ~clk;

    fetch_unit #(.ADDR_W(32), .DATA_W(32), .RESET_PC(32'h0), .FIFO_DEPTH(2)) dut (
        .clk(clk), .reset(reset),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_req_addr(imem_req_addr), .imem_rsp_valid(imem_rsp_valid),
        .imem_rsp_data(imem_rsp_data), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc), .inst_valid(inst_valid), .inst_ready(inst_ready),
        .inst(inst), .inst_pc(inst_pc)
`ifdef FETCH_PERF_EN
        , .perf_fetched(perf_fetched), .perf_bubbles(perf_bubbles)
`endif
    );

    fetch_unit #(.ADDR_W(32), .DATA_W(32), .RESET_PC(32'hFFFF_FFF8), .FIFO_DEPTH(2)) dut_wrap (
        .clk(clk), .reset(reset),
        .imem_req_valid(req_valid2), .imem_req_ready(imem_req_ready),
        .imem_req_addr(req_addr2), .imem_rsp_valid(imem_rsp_valid),
        .imem_rsp_data(imem_rsp_data), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc), .inst_valid(inst_valid2), .inst_ready(inst_ready),
        .inst(inst2), .inst_pc(inst_pc2)
`ifdef FETCH_PERF_EN
        , .perf_fetched(perf_fetched2), .perf_bubbles(perf_bubbles2)
`endif
    );

    function automatic logic [31:0] memword(input logic [31:0] a);
        return a * 32'h9E37_79B9 + 32'h1234_5677;
    endfunction

    task automatic do_reset();
        reset = 1'b0;
        imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
        redirect_valid = 1'b0; redirect_pc = '0; inst_ready = 1'b0;
        mem_pend = 1'b0; mem_wait = 0; mem_lat = 1;
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    // One clock: sample outputs at the negedge, drive inputs, advance the memory model.
    task automatic cycle(input logic rdy, input logic irdy, input logic redir, input logic [31:0] rpc);
        o_rv = imem_req_valid; o_ra = imem_req_addr; o_iv = inst_valid;
        o_inst = inst; o_ipc = inst_pc;
        o_rv2 = req_valid2; o_ra2 = req_addr2; o_iv2 = inst_valid2; o_ipc2 = inst_pc2;
        pend_before = mem_pend;
        rsp_fire = mem_pend && (mem_wait == 0);
        if (mem_pend && mem_wait != 0) mem_wait--;
        imem_rsp_valid = rsp_fire;
        imem_rsp_data  = rsp_fire ? memword(mem_addr) : $urandom;
        imem_req_ready = rdy; inst_ready = irdy;
        redirect_valid = redir; redirect_pc = rpc;
        acc = o_rv && rdy; acc2 = o_rv2 && rdy;
        pop = o_iv && irdy; pop2 = o_iv2 && irdy;
        @(posedge clk);
        if (rsp_fire) mem_pend = 1'b0;
        if (acc) begin
            mem_pend = 1'b1; mem_addr = o_ra; mem_wait = mem_lat - 1;
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b0;
        imem_req_ready = 1'b1; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
        redirect_valid = 1'b0; redirect_pc = '0; inst_ready = 1'b1;
        @(negedge clk);
        checks++; if (imem_req_valid !== 1'b0) begin failures++; $display("FAIL reset_req_valid got=%b exp=0", imem_req_valid); end
        checks++; if (inst_valid !== 1'b0) begin failures++; $display("FAIL reset_inst_valid got=%b exp=0", inst_valid); end
        checks++; if (inst !== 32'h0) begin failures++; $display("FAIL reset_inst got=%h exp=0", inst); end
        checks++; if (inst_pc !== 32'h0) begin failures++; $display("FAIL reset_inst_pc got=%h exp=0", inst_pc); end
        checks++; if (req_valid2 !== 1'b0) begin failures++; $display("FAIL reset_req_valid2 got=%b exp=0", req_valid2); end
    endtask

    task automatic test_sequential();
        logic [31:0] addrs [3];
        int nacc = 0, npop = 0, first_acc = -1, first_iv = -1;
        do_reset();
        cycle(1, 1, 0, 0);
        checks++; if (o_rv !== 1'b0) begin failures++; $display("FAIL seq_no_req_at_release got=%b exp=0", o_rv); end
        for (int k = 1; k < 40 && npop < 3; k++) begin
            cycle(1, 1, 0, 0);
            if (acc) begin
                if (first_acc < 0) first_acc = k;
                if (nacc < 3) begin addrs[nacc] = o_ra; nacc++; end
            end
            if (o_iv && first_iv < 0) first_iv = k;
            if (pop) begin
                checks++; if (o_ipc !== 32'(npop * 4)) begin failures++; $display("FAIL seq_inst_pc got=%h exp=%h", o_ipc, 32'(npop * 4)); end
                checks++; if (o_inst !== memword(32'(npop * 4))) begin failures++; $display("FAIL seq_inst got=%h exp=%h", o_inst, memword(32'(npop * 4))); end
                npop++;
            end
        end
        checks++; if (npop != 3 || nacc != 3) begin failures++; $display("FAIL seq_timeout pops=%0d accepts=%0d exp=3", npop, nacc); end
        else begin
            checks++; if (addrs[0] !== 32'h0 || addrs[1] !== 32'h4 || addrs[2] !== 32'h8) begin
                failures++; $display("FAIL seq_req_addrs got=%h,%h,%h exp=0,4,8", addrs[0], addrs[1], addrs[2]);
            end
        end
        checks++; if (first_acc != 1) begin failures++; $display("FAIL seq_first_accept_cycle got=%0d exp=1", first_acc); end
        checks++; if (first_iv - first_acc != 2) begin failures++; $display("FAIL seq_inst_valid_latency got=%0d exp=2", first_iv - first_acc); end
    endtask

    task automatic test_backpressure();
        int pushes = 0, npop = 0;
        logic seen_acc = 1'b0;
        do_reset();
        for (int k = 0; k < 14; k++) begin
            cycle(1, 0, 0, 0);
            if (rsp_fire) pushes++;
            if (o_iv) begin
                checks++; if (o_ipc !== 32'h0 || o_inst !== memword(32'h0)) begin
                    failures++; $display("FAIL bp_hold got=%h/%h exp=%h/%h", o_ipc, o_inst, 32'h0, memword(32'h0));
                end
            end
        end
        checks++; if (pushes != 2) begin failures++; $display("FAIL bp_pushes got=%0d exp=2", pushes); end
        checks++; if (o_rv !== 1'b0) begin failures++; $display("FAIL bp_req_gated got=%b exp=0", o_rv); end
        for (int k = 0; k < 20 && !seen_acc; k++) begin
            cycle(1, 1, 0, 0);
            if (pop) begin
                checks++; if (o_ipc !== 32'(npop * 4)) begin failures++; $display("FAIL bp_pop_pc got=%h exp=%h", o_ipc, 32'(npop * 4)); end
                npop++;
            end
            if (acc) begin
                seen_acc = 1'b1;
                checks++; if (o_ra !== 32'h8) begin failures++; $display("FAIL bp_resume_addr got=%h exp=00000008", o_ra); end
            end
        end
        checks++; if (!seen_acc) begin failures++; $display("FAIL bp_resume_timeout got=none exp=accept"); end
    endtask

    task automatic test_req_stall();
        do_reset();
        cycle(0, 1, 0, 0);
        for (int k = 0; k < 5; k++) begin
            cycle(0, 1, 0, 0);
            checks++; if (o_rv !== 1'b1 || o_ra !== 32'h0) begin failures++; $display("FAIL stall_req got=%b/%h exp=1/0", o_rv, o_ra); end
            checks++; if (o_iv !== 1'b0) begin failures++; $display("FAIL stall_no_push got=%b exp=0", o_iv); end
        end
    endtask

    task automatic test_redirect_wait();
        logic found = 1'b0, got_acc = 1'b0, got_pop = 1'b0;
        do_reset();
        mem_lat = 3;
        for (int k = 0; k < 60 && !found; k++) begin
            cycle(1, 1, 0, 0);
            if (acc && o_ra == 32'h10) found = 1'b1;
        end
        checks++; if (!found) begin failures++; $display("FAIL rw_reach_0x10 got=none exp=accept"); end
        cycle(1, 1, 1, 32'h103);
        checks++; if (o_rv !== 1'b0) begin failures++; $display("FAIL rw_in_wait got=%b exp=0", o_rv); end
        cycle(1, 1, 0, 0);
        checks++; if (o_iv !== 1'b0) begin failures++; $display("FAIL rw_flush got=%b exp=0", o_iv); end
        for (int k = 0; k < 30 && !got_pop; k++) begin
            if (acc && !got_acc) begin
                got_acc = 1'b1;
                checks++; if (o_ra !== 32'h100) begin failures++; $display("FAIL rw_target_addr got=%h exp=00000100", o_ra); end
            end
            if (pop) begin
                got_pop = 1'b1;
                checks++; if (o_ipc !== 32'h100 || o_inst !== memword(32'h100)) begin
                    failures++; $display("FAIL rw_first_inst got=%h/%h exp=00000100/%h", o_ipc, o_inst, memword(32'h100));
                end
            end
            if (!got_pop) cycle(1, 1, 0, 0);
        end
        checks++; if (!got_pop) begin failures++; $display("FAIL rw_timeout got=none exp=pop"); end
    endtask

    task automatic test_redirect_rsp();
        logic found = 1'b0, got_pop = 1'b0;
        do_reset();
        mem_lat = 2;
        for (int k = 0; k < 20 && !found; k++) begin
            cycle(1, 0, 0, 0);
            if (acc && o_ra == 32'h4) found = 1'b1;
        end
        checks++; if (!found) begin failures++; $display("FAIL rr_reach_0x4 got=none exp=accept"); end
        cycle(1, 0, 0, 0);
        cycle(1, 1, 1, 32'h200);
        checks++; if (!(rsp_fire && o_iv)) begin failures++; $display("FAIL rr_setup rsp=%b iv=%b exp=1/1", rsp_fire, o_iv); end
        cycle(1, 0, 0, 0);
        checks++; if (o_iv !== 1'b0) begin failures++; $display("FAIL rr_no_push got=%b exp=0", o_iv); end
        checks++; if (o_rv !== 1'b1 || o_ra !== 32'h200) begin failures++; $display("FAIL rr_next_req got=%b/%h exp=1/00000200", o_rv, o_ra); end
        found = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            cycle(1, 0, 0, 0);
            if (acc && o_ra == 32'h204) found = 1'b1;
        end
        checks++; if (!found) begin failures++; $display("FAIL rr_reach_0x204 got=none exp=accept"); end
        checks++; if (inst_valid !== 1'b1 || inst_pc !== 32'h200) begin
            failures++; $display("FAIL rr_pre_reset got=%b/%h exp=1/00000200", inst_valid, inst_pc);
        end
        #2 reset = 1'b0;
        #1;
        checks++; if (imem_req_valid !== 1'b0 || inst_valid !== 1'b0 || inst !== 32'h0 || inst_pc !== 32'h0) begin
            failures++; $display("FAIL rr_async_reset got=%b/%b/%h/%h exp=0/0/0/0", imem_req_valid, inst_valid, inst, inst_pc);
        end
        mem_pend = 1'b0;
        @(negedge clk);
        got_pop = 1'b0;
    endtask

    task automatic test_wrap();
        logic [31:0] exp_a [3];
        int nacc = 0, npop = 0;
        exp_a[0] = 32'hFFFF_FFF8; exp_a[1] = 32'hFFFF_FFFC; exp_a[2] = 32'h0000_0000;
        do_reset();
        for (int k = 0; k < 40 && (nacc < 3 || npop < 3); k++) begin
            cycle(1, 1, 0, 0);
            if (acc2 && nacc < 3) begin
                checks++; if (o_ra2 !== exp_a[nacc]) begin failures++; $display("FAIL wrap_req_addr got=%h exp=%h", o_ra2, exp_a[nacc]); end
                nacc++;
            end
            if (pop2 && npop < 3) begin
                checks++; if (o_ipc2 !== exp_a[npop]) begin failures++; $display("FAIL wrap_inst_pc got=%h exp=%h", o_ipc2, exp_a[npop]); end
                npop++;
            end
        end
        checks++; if (nacc != 3 || npop != 3) begin failures++; $display("FAIL wrap_timeout accepts=%0d pops=%0d exp=3", nacc, npop); end
    endtask

    task automatic test_random();
        logic [31:0] exp_fetch = '0, exp_deliver = '0, rpc;
        logic        rdy, irdy, redir;
        logic        p_valid = 1'b0, p_rv, p_iv, p_rdy, p_irdy, p_redir;
        logic [31:0] p_ra, p_inst, p_ipc;
        int          npops = 0;
        do_reset();
        for (int k = 0; k < 800; k++) begin
            rdy   = ($urandom_range(0, 3) != 0);
            irdy  = ($urandom_range(0, 2) != 0);
            redir = ($urandom_range(0, 24) == 0);
            rpc   = $urandom;
            mem_lat = $urandom_range(1, 3);
            cycle(rdy, irdy, redir, rpc);
            if (acc) begin
                checks++; if (pend_before) begin failures++; $display("FAIL rnd_outstanding got=2 exp=1 addr=%h", o_ra); end
            end
            if (acc && !redir) begin
                checks++; if (o_ra !== exp_fetch) begin failures++; $display("FAIL rnd_req_addr got=%h exp=%h", o_ra, exp_fetch); end
                exp_fetch = exp_fetch + 32'd4;
            end
            if (pop && !redir) begin
                checks++; if (o_ipc !== exp_deliver || o_inst !== memword(exp_deliver)) begin
                    failures++; $display("FAIL rnd_deliver got=%h/%h exp=%h/%h", o_ipc, o_inst, exp_deliver, memword(exp_deliver));
                end
                exp_deliver = exp_deliver + 32'd4;
                npops++;
            end
            if (redir) begin
                exp_fetch   = {rpc[31:2], 2'b00};
                exp_deliver = {rpc[31:2], 2'b00};
            end
            if (p_valid && p_iv && !p_irdy && !p_redir) begin
                checks++; if (o_iv !== 1'b1 || o_inst !== p_inst || o_ipc !== p_ipc) begin
                    failures++; $display("FAIL rnd_inst_hold got=%b/%h/%h exp=1/%h/%h", o_iv, o_ipc, o_inst, p_ipc, p_inst);
                end
            end
            if (p_valid && p_rv && !p_rdy && !p_redir) begin
                checks++; if (o_rv !== 1'b1 || o_ra !== p_ra) begin
                    failures++; $display("FAIL rnd_req_hold got=%b/%h exp=1/%h", o_rv, o_ra, p_ra);
                end
            end
            p_valid = 1'b1; p_rv = o_rv; p_iv = o_iv; p_rdy = rdy; p_irdy = irdy; p_redir = redir;
            p_ra = o_ra; p_inst = o_inst; p_ipc = o_ipc;
        end
        checks++; if (npops < 50) begin failures++; $display("FAIL rnd_progress got=%0d exp>=50", npops); end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_sequential();
        test_backpressure();
        test_req_stall();
        test_redirect_wait();
        test_redirect_rsp();
        test_wrap();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
